// File: rtl/banco_registros_pkg.sv
// Shared datapath constants for the MIPS register file: default widths,
// register count and the architectural register-index aliases used by control.
package banco_registros_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 29;
   localparam int REG_RA   = 31;

endpackage : banco_registros_pkg

// File: rtl/banco_registros_rd.sv
// One combinational read port of the register file: forces $0 to zero and,
// when BANCO_REGISTROS_BYPASS_EN is defined, forwards same-cycle write data.
module banco_registros_rd
   import banco_registros_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic [ADDR_W-1:0] rd_idx,
   input  logic [DATA_W-1:0] rd_stored,
`ifdef BANCO_REGISTROS_BYPASS_EN
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_idx,
   input  logic [DATA_W-1:0] wr_data,
`endif
   output logic [DATA_W-1:0] rd_data
);

   // Read mux: $0 forcing first, then optional forwarding of the pending write.
   always_comb begin
      rd_data = rd_stored;
      if (rd_idx == ADDR_W'(REG_ZERO)) begin
         rd_data = {DATA_W{1'b0}};
      end else begin
`ifdef BANCO_REGISTROS_BYPASS_EN
         // Forwarding is held off during reset so the port shows stored contents.
         if (rst_n && wr_en && (wr_idx != ADDR_W'(REG_ZERO)) && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
         end else begin
            rd_data = rd_stored;
         end
`else
         rd_data = rd_stored;
`endif
      end
   end

endmodule : banco_registros_rd

// File: rtl/banco_registros.sv
// 32 x 32-bit MIPS register file: two combinational read ports, one clocked
// write port, $0 hardwired to zero. Optional bypass via BANCO_REGISTROS_BYPASS_EN.
module banco_registros
   import banco_registros_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteReg,
   input  logic [DATA_W-1:0] WriteData,
   input  logic [ADDR_W-1:0] ReadReg1,
   input  logic [ADDR_W-1:0] ReadReg2,
   output logic [DATA_W-1:0] ReadData1,
   output logic [DATA_W-1:0] ReadData2
);

   localparam int NUM = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NUM];
   logic [DATA_W-1:0] regs_d [NUM];

   // Next-state of the storage array: single write port, $0 never changes.
   always_comb begin
      regs_d = regs_q;
      if (RegWrite && (WriteReg != ADDR_W'(REG_ZERO))) begin
         regs_d[WriteReg] = WriteData;
      end else begin
         regs_d = regs_q;
      end
      regs_d[REG_ZERO] = {DATA_W{1'b0}};
   end

   // Storage register; synchronous reset wins over any write on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs_q <= '{default: {DATA_W{1'b0}}};
      end else begin
         regs_q <= regs_d;
      end
   end

   banco_registros_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd1 (
      .rd_idx    (ReadReg1),
      .rd_stored (regs_q[ReadReg1]),
`ifdef BANCO_REGISTROS_BYPASS_EN
      .rst_n     (rst_n),
      .wr_en     (RegWrite),
      .wr_idx    (WriteReg),
      .wr_data   (WriteData),
`endif
      .rd_data   (ReadData1)
   );

   banco_registros_rd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd2 (
      .rd_idx    (ReadReg2),
      .rd_stored (regs_q[ReadReg2]),
`ifdef BANCO_REGISTROS_BYPASS_EN
      .rst_n     (rst_n),
      .wr_en     (RegWrite),
      .wr_idx    (WriteReg),
      .wr_data   (WriteData),
`endif
      .rd_data   (ReadData2)
   );

endmodule : banco_registros

// File: tb/tb_banco_registros.sv
// Self-checking bench for banco_registros: directed vector table followed by
// randomized traffic compared against an array-based reference model.
module tb_banco_registros;
   import banco_registros_pkg::*;

   localparam int DW = DATA_W_DEF;
   localparam int AW = ADDR_W_DEF;

`ifdef BANCO_REGISTROS_BYPASS_EN
   localparam logic [DW-1:0] RDW_PRE = 32'h2222_2222;
`else
   localparam logic [DW-1:0] RDW_PRE = 32'h1111_1111;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          RegWrite;
   logic [AW-1:0] WriteReg;
   logic [DW-1:0] WriteData;
   logic [AW-1:0] ReadReg1;
   logic [AW-1:0] ReadReg2;
   logic [DW-1:0] ReadData1;
   logic [DW-1:0] ReadData2;

   always #5 clk = ~clk;

   banco_registros dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .RegWrite  (RegWrite),
      .WriteReg  (WriteReg),
      .WriteData (WriteData),
      .ReadReg1  (ReadReg1),
      .ReadReg2  (ReadReg2),
      .ReadData1 (ReadData1),
      .ReadData2 (ReadData2)
   );

   typedef struct {
      logic          rst;
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [AW-1:0] r1;
      logic [AW-1:0] r2;
      logic [DW-1:0] e1;
      logic [DW-1:0] e2;
   } vec_t;

   localparam int NVEC = 15;
   vec_t tbl [NVEC];

   logic [DW-1:0] model [NUM_REGS];
   int checks = 0;
   int errors = 0;

   // What a read port should show right now, from the model and current inputs.
   function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] idx);
      if (idx == AW'(REG_ZERO)) return '0;
`ifdef BANCO_REGISTROS_BYPASS_EN
      if (rst_n && RegWrite && WriteReg != '0 && WriteReg == idx) return WriteData;
`endif
      return model[idx];
   endfunction

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
      rst_n     = rst;
      RegWrite  = we;
      WriteReg  = wa;
      WriteData = wd;
      ReadReg1  = r1;
      ReadReg2  = r2;
   endtask

   // Advance one rising edge, updating the model with the architectural rules.
   task automatic edge_update();
      @(posedge clk);
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      end else if (RegWrite && WriteReg != '0) begin
         model[WriteReg] = WriteData;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
      drive(1'b0, 1'b0, '0, '0, '0, '0);

      //           rst   we    wa              wd             r1              r2              e1             e2
      tbl[0]  = '{1'b1, 1'b1, 5'd8,          32'hDEADBEEF, 5'd1,          5'd0,          32'h0,         32'h0};
      tbl[1]  = '{1'b0, 1'b0, 5'd0,          32'h0,        5'd8,          5'd0,          32'hDEADBEEF,  32'h0};
      tbl[2]  = '{1'b1, 1'b1, 5'd5,          32'h12345678, 5'd8,          5'd0,          32'h0,         32'h0};
      tbl[3]  = '{1'b1, 1'b1, 5'd0,          32'hFFFFFFFF, 5'd5,          5'd5,          32'h12345678,  32'h12345678};
      tbl[4]  = '{1'b1, 1'b1, 5'd3,          32'hA5A5A5A5, 5'd0,          5'd5,          32'h0,         32'h12345678};
      tbl[5]  = '{1'b0, 1'b1, 5'd3,          32'hC3C3C3C3, 5'd3,          5'd3,          32'hA5A5A5A5,  32'hA5A5A5A5};
      tbl[6]  = '{1'b1, 1'b1, 5'd9,          32'h11111111, 5'd3,          5'd5,          32'h0,         32'h0};
      tbl[7]  = '{1'b1, 1'b1, AW'(REG_RA),   32'h0000ABCD, 5'd9,          5'd0,          32'h11111111,  32'h0};
      tbl[8]  = '{1'b1, 1'b1, 5'd9,          32'h22222222, 5'd9,          AW'(REG_RA),   RDW_PRE,       32'h0000ABCD};
      tbl[9]  = '{1'b1, 1'b0, AW'(REG_RA),   32'h0,        5'd9,          AW'(REG_RA),   32'h22222222,  32'h0000ABCD};
      tbl[10] = '{1'b1, 1'b0, AW'(REG_RA),   32'h0,        5'd9,          AW'(REG_RA),   32'h22222222,  32'h0000ABCD};
      tbl[11] = '{1'b1, 1'b0, AW'(REG_RA),   32'h0,        AW'(REG_RA),   5'd0,          32'h0000ABCD,  32'h0};
      tbl[12] = '{1'b1, 1'b1, AW'(REG_SP),   32'h5A5A0029, AW'(REG_RA),   5'd9,          32'h0000ABCD,  32'h22222222};
      tbl[13] = '{1'b1, 1'b0, 5'd0,          32'h0,        AW'(REG_SP),   5'd0,          32'h5A5A0029,  32'h0};
      tbl[14] = '{1'b0, 1'b0, 5'd0,          32'h0,        AW'(REG_SP),   AW'(REG_RA),   32'h5A5A0029,  32'h0000ABCD};

      #1;
      edge_update();
      edge_update();

      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].rst, tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].r1, tbl[i].r2);
         #3;
         check($sformatf("vec%0d_rd1", i), ReadData1, tbl[i].e1);
         check($sformatf("vec%0d_rd2", i), ReadData2, tbl[i].e2);
         edge_update();
      end

      // Post-reset sweep: every register must read zero after the last table reset.
      for (int i = 0; i < NUM_REGS; i++) begin
         drive(1'b1, 1'b0, '0, '0, AW'(i), AW'(NUM_REGS - 1 - i));
         #1;
         check("post_reset_rd1", ReadData1, '0);
         check("post_reset_rd2", ReadData2, '0);
      end

      // Same-cycle read-during-write, then post-edge visibility.
      drive(1'b1, 1'b1, 5'd9, 32'h11111111, 5'd0, 5'd0);
      edge_update();
      drive(1'b1, 1'b1, 5'd9, 32'h22222222, 5'd9, 5'd9);
      #3;
      check("rdw_pre_rd1", ReadData1, RDW_PRE);
      check("rdw_pre_rd2", ReadData2, RDW_PRE);
      edge_update();
      drive(1'b1, 1'b0, 5'd9, 32'h0, 5'd9, 5'd0);
      #3;
      check("rdw_post_rd1", ReadData1, 32'h22222222);
      edge_update();

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0] wa;
         wa = AW'($urandom);
         drive(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
               ($urandom_range(0, 3) == 0) ? wa : AW'($urandom),
               ($urandom_range(0, 3) == 0) ? wa : AW'($urandom));
         #3;
         check("rand_rd1", ReadData1, expect_rd(ReadReg1));
         check("rand_rd2", ReadData2, expect_rd(ReadReg2));
         edge_update();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_banco_registros
